axi_read_responder: RTL and testbench

// AXI4 read-channel slave (AR + R) serving bursts from an internal 64-bit word memory.

---
 rtl/axi_pkg.sv | 23 ++
 rtl/axi_burst_addr_gen.sv | 52 +++++
 rtl/axi_read_responder.sv | 183 ++++++++++++++++++
 tb/tb_axi_read_responder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI types and constants for the read (and future write) responders.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_state_t;

  // A WRAP burst must cover 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI burst next-address generator with burst legality flag.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  legal
);

  logic [ADDR_WIDTH-1:0] step_s;
  logic [ADDR_WIDTH-1:0] incr_s;
  logic [ADDR_WIDTH-1:0] wrap_bytes_s;
  logic [ADDR_WIDTH-1:0] wrap_base_s;

  // next beat address and legality for the selected burst type
  always_comb begin
    step_s       = ADDR_WIDTH'(1) << size;
    incr_s       = addr + step_s;
    wrap_bytes_s = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
    wrap_base_s  = addr & ~(wrap_bytes_s - ADDR_WIDTH'(1));
    next_addr    = addr;
    legal        = 1'b0;
    case (burst)
      BURST_FIXED: begin
        next_addr = addr;
        legal     = (size <= 3'd3);
      end
      BURST_INCR: begin
        next_addr = incr_s;
        legal     = (size <= 3'd3);
      end
      BURST_WRAP: begin
        if (incr_s >= (wrap_base_s + wrap_bytes_s)) begin
          next_addr = wrap_base_s;
        end else begin
          next_addr = incr_s;
        end
        legal = (size <= 3'd3) && wrap_len_ok(len);
      end
      default: begin
        next_addr = addr;
        legal     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/axi_read_responder.sv
// AXI4 read-channel slave serving FIXED/INCR/WRAP bursts from a preloadable 64-bit word memory.
module axi_read_responder
  import axi_pkg::*;
#(
  parameter int              ID_WIDTH   = 13,
  parameter int              ADDR_WIDTH = 64,
  parameter int              DATA_WIDTH = 64,
  parameter int              MEM_WORDS  = 4096,
  parameter longint unsigned BASE_ADDR  = 64'd0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ID_WIDTH-1:0]          s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
  input  logic [7:0]                   s_axi_arlen,
  input  logic [2:0]                   s_axi_arsize,
  input  logic [1:0]                   s_axi_arburst,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [ID_WIDTH-1:0]          s_axi_rid,
  output logic [DATA_WIDTH-1:0]        s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rlast,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  input  logic                         mem_we,
  input  logic [$clog2(MEM_WORDS)-1:0] mem_waddr,
  input  logic [63:0]                  mem_wdata
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  rd_state_t             state_r, state_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [2:0]            size_r;
  logic [7:0]            len_r, cnt_r;
  logic [1:0]            burst_r;
  logic                  burst_err_r;
  logic                  arready_r, rvalid_r, rlast_r;
  logic [1:0]            rresp_r;
  logic [ID_WIDTH-1:0]   rid_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic [63:0]           mem [0:MEM_WORDS-1];

  logic [ADDR_WIDTH-1:0] gen_addr_s, next_addr_s, load_addr_s, offset_s;
  logic [2:0]            gen_size_s;
  logic [7:0]            gen_len_s, load_cnt_s;
  logic [1:0]            gen_burst_s;
  logic                  legal_s, under_s, oor_s, load_err_s, beat_err_s;
  logic                  ar_hs_s, r_hs_s, advance_s, done_s, load_s;
  logic [IDX_W-1:0]      rd_idx_s;

  // In IDLE the generator judges the incoming request; in BURST it steps the captured one.
  always_comb begin
    if (state_r == IDLE) begin
      gen_addr_s  = s_axi_araddr;
      gen_size_s  = s_axi_arsize;
      gen_len_s   = s_axi_arlen;
      gen_burst_s = s_axi_arburst;
    end else begin
      gen_addr_s  = addr_r;
      gen_size_s  = size_r;
      gen_len_s   = len_r;
      gen_burst_s = burst_r;
    end
  end

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .addr      (gen_addr_s),
    .size      (gen_size_s),
    .len       (gen_len_s),
    .burst     (gen_burst_s),
    .next_addr (next_addr_s),
    .legal     (legal_s)
  );

  // handshakes and the address/count/error of the beat loaded at this edge
  always_comb begin
    ar_hs_s   = s_axi_arvalid && arready_r;
    r_hs_s    = rvalid_r && s_axi_rready;
    advance_s = (state_r == BURST) && r_hs_s && !rlast_r;
    done_s    = r_hs_s && rlast_r;
    load_s    = ar_hs_s || advance_s;
    if (ar_hs_s) begin
      load_addr_s = s_axi_araddr;
      load_cnt_s  = s_axi_arlen;
      load_err_s  = !legal_s;
    end else begin
      load_addr_s = next_addr_s;
      load_cnt_s  = cnt_r - 8'd1;
      load_err_s  = burst_err_r;
    end
  end

  // word index and range check of the beat being loaded
  always_comb begin
    {under_s, offset_s} = {1'b0, load_addr_s} - {1'b0, ADDR_WIDTH'(BASE_ADDR)};
    oor_s      = under_s || ((offset_s >> 3) >= ADDR_WIDTH'(MEM_WORDS));
    beat_err_s = load_err_s || oor_s;
    rd_idx_s   = offset_s[IDX_W+2:3];
  end

  // FSM next state
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (ar_hs_s) state_s = BURST;
        else         state_s = IDLE;
      end
      BURST: begin
        if (done_s) state_s = IDLE;
        else        state_s = BURST;
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // request capture and beat address/count tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_r      <= '0;
      size_r      <= 3'd0;
      len_r       <= 8'd0;
      burst_r     <= 2'd0;
      cnt_r       <= 8'd0;
      burst_err_r <= 1'b0;
      rid_r       <= '0;
    end else if (ar_hs_s) begin
      addr_r      <= s_axi_araddr;
      size_r      <= s_axi_arsize;
      len_r       <= s_axi_arlen;
      burst_r     <= s_axi_arburst;
      cnt_r       <= s_axi_arlen;
      burst_err_r <= !legal_s;
      rid_r       <= s_axi_arid;
    end else if (advance_s) begin
      addr_r <= next_addr_s;
      cnt_r  <= cnt_r - 8'd1;
    end
  end

  // registered R channel; values hold while a beat waits for rready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rresp_r   <= RESP_OKAY;
      rdata_r   <= '0;
    end else begin
      arready_r <= (state_s == IDLE);
      if (load_s) begin
        rvalid_r <= 1'b1;
        rlast_r  <= (load_cnt_s == 8'd0);
        rresp_r  <= beat_err_s ? RESP_SLVERR : RESP_OKAY;
        rdata_r  <= beat_err_s ? '0 : mem[rd_idx_s];
      end else if (done_s) begin
        rvalid_r <= 1'b0;
        rlast_r  <= 1'b0;
      end
    end
  end

  // preload port; a same-cycle fetch of this word still sees the old contents
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign s_axi_arready = arready_r;
  assign s_axi_rvalid  = rvalid_r;
  assign s_axi_rlast   = rlast_r;
  assign s_axi_rresp   = rresp_r;
  assign s_axi_rid     = rid_r;
  assign s_axi_rdata   = rdata_r;

endmodule

// File: tb/tb_axi_read_responder.sv
// Randomized self-checking bench for axi_read_responder against a burst-level reference model.
module tb_axi_read_responder;

  localparam int IDW = 13;
  localparam int AW  = 64;
  localparam int MW  = 4096;

  logic           clk = 1'b0;
  logic           reset;
  logic [IDW-1:0] arid;
  logic [AW-1:0]  araddr;
  logic [7:0]     arlen;
  logic [2:0]     arsize;
  logic [1:0]     arburst;
  logic           arvalid, arready;
  logic [IDW-1:0] rid;
  logic [63:0]    rdata;
  logic [1:0]     rresp;
  logic           rlast, rvalid, rready;
  logic           mem_we;
  logic [11:0]    mem_waddr;
  logic [63:0]    mem_wdata;

  logic [63:0] shadow   [0:MW-1];
  logic [63:0] exp_data [0:255];
  logic [1:0]  exp_resp [0:255];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_read_responder #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(64), .MEM_WORDS(MW)) dut (
    .clk(clk), .reset(reset),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected beats from the burst rules: beat i lives at start + i*step, folded into the wrap window.
  task automatic model(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                       input logic [1:0] burst);
    longint unsigned step, wb, base, a;
    bit bad_all;
    bad_all = (size > 3'd3) || (burst == 2'd3) ||
              ((burst == 2'd2) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    step = 64'd1 << size;
    wb   = (longint'(len) + 1) * step;
    for (int i = 0; i <= int'(len); i++) begin
      case (burst)
        2'd1: a = addr + longint'(i) * step;
        2'd2: begin
          base = (addr / wb) * wb;
          a    = base + ((addr - base) + longint'(i) * step) % wb;
        end
        default: a = addr;
      endcase
      if (bad_all || (a / 8) >= MW) begin
        exp_data[i] = 64'd0;
        exp_resp[i] = 2'd2;
      end else begin
        exp_data[i] = shadow[a / 8];
        exp_resp[i] = 2'd0;
      end
    end
  endtask

  // mode: 0 rready always high, 1 toggling starting low, 2 random
  task automatic run_burst(input logic [IDW-1:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode,
                           input bit collide);
    int cyc, beat, widx;
    bit tog, rr;
    logic [63:0] cdata;
    model(addr, len, size, burst);
    @(negedge clk);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    cyc = 0;
    while (!arready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("ar_accept", {63'd0, arready}, 64'd1);
    widx = 0; cdata = 64'd0;
    if (collide) begin
      widx = int'(addr >> 3);
      cdata = ~shadow[widx];
      mem_we = 1'b1; mem_waddr = widx[11:0]; mem_wdata = cdata;
    end
    @(negedge clk);
    arvalid = 1'b0;
    mem_we = 1'b0;
    if (collide) shadow[widx] = cdata;
    beat = 0; cyc = 0; tog = 1'b0;
    while (beat <= int'(len) && cyc < 32 * (int'(len) + 1) + 32) begin
      check("rvalid", {63'd0, rvalid}, 64'd1);
      check("arready_busy", {63'd0, arready}, 64'd0);
      check("rdata", rdata, exp_data[beat]);
      check("rresp", {62'd0, rresp}, {62'd0, exp_resp[beat]});
      check("rlast", {63'd0, rlast}, {63'd0, beat == int'(len)});
      check("rid", {51'd0, rid}, {51'd0, id});
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      rready = rr;
      if (rr) beat++;
      @(negedge clk);
      cyc++;
    end
    check("rvalid_end", {63'd0, rvalid}, 64'd0);
    check("arready_end", {63'd0, arready}, 64'd1);
    rready = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    logic [7:0]  l;
    logic [2:0]  s;
    logic [1:0]  b;
    int          w;
    reset = 1'b0; arid = '0; araddr = '0; arlen = 8'd0; arsize = 3'd0; arburst = 2'd0;
    arvalid = 1'b0; rready = 1'b1; mem_we = 1'b0; mem_waddr = 12'd0; mem_wdata = 64'd0;
    #1 reset = 1'b1;
    @(negedge clk); @(negedge clk);
    check("rst_arready", {63'd0, arready}, 64'd0);
    check("rst_rvalid", {63'd0, rvalid}, 64'd0);
    check("rst_rlast", {63'd0, rlast}, 64'd0);
    check("rst_rresp", {62'd0, rresp}, 64'd0);
    check("rst_rid", {51'd0, rid}, 64'd0);
    check("rst_rdata", rdata, 64'd0);
    reset = 1'b0;
    check("arready_before_clk", {63'd0, arready}, 64'd0);
    @(negedge clk);
    check("arready_after_clk", {63'd0, arready}, 64'd1);

    for (int i = 0; i < MW; i++) begin
      shadow[i] = (i < 8) ? 64'h1000 + 64'(i) : {$urandom, $urandom};
      mem_we = 1'b1; mem_waddr = i[11:0]; mem_wdata = shadow[i];
      @(negedge clk);
    end
    mem_we = 1'b0;

    run_burst(13'h0011, 64'h0,  8'd7, 3'd3, 2'd1, 0, 1'b0);
    run_burst(13'h0022, 64'h28, 8'd7, 3'd3, 2'd2, 0, 1'b0);
    run_burst(13'h0033, 64'h10, 8'd3, 3'd3, 2'd0, 1, 1'b0);
    run_burst(13'h0044, 64'h8,  8'd2, 3'd4, 2'd1, 0, 1'b0);
    run_burst(13'h0055, 64'h8,  8'd1, 3'd3, 2'd3, 0, 1'b0);
    run_burst(13'h0066, 64'h8,  8'd2, 3'd3, 2'd2, 1, 1'b0);
    run_burst(13'h0077, 64'((MW - 2) * 8), 8'd3, 3'd3, 2'd1, 0, 1'b0);
    run_burst(13'h0088, 64'h48, 8'd0, 3'd3, 2'd1, 0, 1'b1);
    run_burst(13'h0099, 64'h48, 8'd0, 3'd3, 2'd1, 0, 1'b0);

    // reset while the third beat of an 8-beat burst is on the bus
    @(negedge clk);
    arid = 13'h0abc; araddr = 64'h0; arlen = 8'd7; arsize = 3'd3; arburst = 2'd1; arvalid = 1'b1;
    w = 0;
    while (!arready && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    arvalid = 1'b0;
    @(negedge clk); @(negedge clk);
    check("mid_rdata", rdata, 64'h1002);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_rvalid", {63'd0, rvalid}, 64'd0);
    check("mid_rst_rlast", {63'd0, rlast}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_arready", {63'd0, arready}, 64'd1);
    check("post_rst_rvalid", {63'd0, rvalid}, 64'd0);
    run_burst(13'h1abc, 64'h20, 8'd3, 3'd3, 2'd1, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      w = $urandom_range(0, 9);
      b = (w < 4) ? 2'd1 : (w < 7) ? 2'd2 : (w < 9) ? 2'd0 : 2'd3;
      s = ($urandom_range(0, 9) == 0) ? 3'd4 : 3'($urandom_range(0, 3));
      if (b == 2'd2 && $urandom_range(0, 4) != 0) begin
        w = $urandom_range(1, 4);
        l = 8'((1 << w) - 1);
      end else begin
        l = 8'($urandom_range(0, 15));
      end
      a = 64'($urandom_range(0, MW * 8 + 255));
      if (k % 5 == 0) a = 64'((MW - 3) * 8) + 64'($urandom_range(0, 23));
      if (b == 2'd2) a = a & ~((64'd1 << s) - 64'd1);
      run_burst(13'($urandom), a, l, s, b, $urandom_range(0, 2), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
